// File: rtl/spi_slave_sync_if.sv
// Pin-side and user-side signals of the oversampled SPI responder.
// Handshake: a transmit byte moves from user logic into the holding buffer
// on every clk edge where tx_valid && tx_ready are both high; tx_valid may
// be raised at any time, tx_ready is high exactly while the buffer is empty,
// and the byte must stay stable while tx_valid is high and tx_ready is low.
// rx_valid is a one-cycle pulse with no back-pressure.
interface spi_slave_sync_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              busy;
  logic              state_dbg;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy, state_dbg
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy, state_dbg
  );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder, MSB first. SCLK, CS_N and MOSI are oversampled in
// the clk domain; all shifting happens on detected edges of the synced SCLK.
// Transmit words come from a one-entry holding buffer that is reloaded into
// the shift register at frame start and after every completed word.
module spi_slave_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_slave_sync_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // synchronizer chains and one-cycle-delayed copies for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_dly_q;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  state_t            state_q,     state_d;
  logic [DATA_W-1:0] tx_buf_q,    tx_buf_d;
  logic              tx_full_q,   tx_full_d;
  logic [DATA_W-1:0] sh_tx_q,     sh_tx_d;
  logic [DATA_W-1:0] sh_rx_q,     sh_rx_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic              word_done_q, word_done_d;
  logic [DATA_W-1:0] rx_data_q,   rx_data_d;
  logic              rx_valid_q,  rx_valid_d;
  logic              underrun_q,  underrun_d;
  logic              miso_q,      miso_d;

  // shift the raw pins through the synchronizer chains; cs_n resets low so
  // a select held through reset never looks like a falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s &  sclk_dly_q;
  assign cs_rise   =  cs_s   & ~cs_dly_q;
  assign cs_fall   = ~cs_s   &  cs_dly_q;

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      sh_tx_q     <= '0;
      sh_rx_q     <= '0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      sh_tx_q     <= sh_tx_d;
      sh_rx_q     <= sh_rx_d;
      bit_cnt_q   <= bit_cnt_d;
      word_done_q <= word_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
    end
  end

  // next-state: frame control, word load, bit shifting and the tx handshake
  always_comb begin
    state_d     = state_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    sh_tx_d     = sh_tx_q;
    sh_rx_d     = sh_rx_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_d = word_done_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    miso_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          // word load uses the buffer as it stood before this cycle
          if (tx_full_q) begin
            sh_tx_d = tx_buf_q;
          end else begin
            sh_tx_d    = '0;
            underrun_d = 1'b1;
          end
          tx_full_d   = 1'b0;
          sh_rx_d     = '0;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          state_d     = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (cs_rise) begin
          // deselect wins over any coincident sclk edge; partial bits dropped
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (sclk_rise) begin
          sh_rx_d = {sh_rx_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d   = {sh_rx_q[DATA_W-2:0], mosi_s};
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (word_done_q) begin
            if (tx_full_q) begin
              sh_tx_d = tx_buf_q;
            end else begin
              sh_tx_d    = '0;
              underrun_d = 1'b1;
            end
            tx_full_d   = 1'b0;
            word_done_d = 1'b0;
          end else begin
            sh_tx_d = {sh_tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // accept after the load so a same-cycle byte lands for the next word
    if (bus.tx_valid && !tx_full_q) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end

    if (state_d == ST_ACTIVE) begin
      miso_d = sh_tx_d[DATA_W-1];
    end
  end

  assign bus.miso        = miso_q;
  assign bus.tx_ready    = ~tx_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.busy        = (state_q == ST_ACTIVE);
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a bit-banged SPI master, an rx scoreboard
// fed from an expected queue, and immediate assertions at every check point.
module tb_spi_slave_sync;
  localparam int W = 8;

  logic clk;
  logic reset;

  spi_slave_sync_if #(.DATA_W(W)) bus ();

  spi_slave_sync #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int un_cnt   = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every rx_valid pulse must match the next expected word
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
        else check("rx_word", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (bus.tx_underrun) un_cnt++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    bus.cs_n = 1'b0;
    wait_clks(6);
  endtask

  task automatic cs_high();
    wait_clks(6);
    bus.cs_n = 1'b1;
    wait_clks(6);
  endtask

  // drive nbits of mo MSB first; miso is sampled just before each rise
  task automatic xfer_bits(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[W-1-i];
      wait_clks(6);
      mi[W-1-i] = bus.miso;
      bus.sclk = 1'b1;
      wait_clks(6);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic push_tx(input logic [W-1:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    wait_clks(1);
    bus.tx_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] mi;
    int rx0, un0;

    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
    reset = 1'b1;
    wait_clks(3);
    check("rst_miso", bus.miso, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_underrun", bus.tx_underrun, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_ready", bus.tx_ready, 1);
    reset = 1'b0;
    wait_clks(6);

    // 1: preloaded A5 out, 3C in
    push_tx(8'hA5);
    check("t1_ready_full", bus.tx_ready, 0);
    check("t1_busy_idle", bus.busy, 0);
    un0 = un_cnt;
    exp_q.push_back(8'h3C);
    cs_low();
    check("t1_busy_active", bus.busy, 1);
    xfer_bits(8'h3C, 8, mi);
    check("t1_miso", mi, 8'hA5);
    check("t1_no_underrun", un_cnt - un0, 0);
    cs_high();
    check("t1_busy_end", bus.busy, 0);
    check("t1_rx_data", bus.rx_data, 8'h3C);
    check("t1_rx_cnt", rx_cnt, 1);
    // the reload after the last bit found the buffer empty
    check("t1_end_underrun", un_cnt - un0, 1);

    // 2: two-word frame, 11 then 22 offered after the first load
    push_tx(8'h11);
    check("t2_ready_full", bus.tx_ready, 0);
    un0 = un_cnt;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    bus.cs_n = 1'b0;
    wait_clks(4);
    check("t2_ready_after_load", bus.tx_ready, 1);
    push_tx(8'h22);
    check("t2_ready_after_accept", bus.tx_ready, 0);
    wait_clks(2);
    xfer_bits(8'hF0, 8, mi);
    check("t2_miso_w0", mi, 8'h11);
    wait_clks(4);
    check("t2_ready_after_reload", bus.tx_ready, 1);
    xfer_bits(8'h0F, 8, mi);
    check("t2_miso_w1", mi, 8'h22);
    cs_high();
    check("t2_rx_data", bus.rx_data, 8'h0F);
    check("t2_rx_cnt", rx_cnt, 3);
    check("t2_underrun", un_cnt - un0, 1);

    // 3: empty buffer underruns at frame start and after the word
    un0 = un_cnt;
    exp_q.push_back(8'h55);
    cs_low();
    check("t3_start_underrun", un_cnt - un0, 1);
    xfer_bits(8'h55, 8, mi);
    check("t3_miso", mi, 8'h00);
    cs_high();
    check("t3_rx_data", bus.rx_data, 8'h55);
    check("t3_underrun", un_cnt - un0, 2);

    // 4: abort after five rises, then a clean 81 frame
    rx0 = rx_cnt;
    cs_low();
    xfer_bits(8'hFF, 5, mi);
    cs_high();
    check("t4_abort_rx_cnt", rx_cnt - rx0, 0);
    check("t4_abort_rx_data", bus.rx_data, 8'h55);
    check("t4_abort_busy", bus.busy, 0);
    exp_q.push_back(8'h81);
    cs_low();
    xfer_bits(8'h81, 8, mi);
    cs_high();
    check("t4_rx_data", bus.rx_data, 8'h81);
    check("t4_rx_cnt", rx_cnt - rx0, 1);

    // 5: reset mid-word with cs_n held low
    rx0 = rx_cnt;
    cs_low();
    xfer_bits(8'hAA, 3, mi);
    reset = 1'b1;
    wait_clks(3);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_miso", bus.miso, 0);
    check("t5_rst_rx_data", bus.rx_data, 0);
    check("t5_rst_tx_ready", bus.tx_ready, 1);
    reset = 1'b0;
    wait_clks(6);
    xfer_bits(8'hFF, 8, mi);
    check("t5_no_frame_busy", bus.busy, 0);
    check("t5_no_frame_miso", mi, 8'h00);
    check("t5_no_frame_rx", rx_cnt - rx0, 0);
    cs_high();
    exp_q.push_back(8'hC3);
    cs_low();
    xfer_bits(8'hC3, 8, mi);
    cs_high();
    check("t5_rx_data", bus.rx_data, 8'hC3);

    // 6: tx_valid coincides with the frame-start load on an empty buffer
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    bus.cs_n = 1'b0;
    wait_clks(2);
    bus.tx_data  = 8'h77;
    bus.tx_valid = 1'b1;
    wait_clks(1);
    bus.tx_valid = 1'b0;
    check("t6_underrun_pulse", bus.tx_underrun, 1);
    check("t6_ready_stored", bus.tx_ready, 0);
    check("t6_busy", bus.busy, 1);
    wait_clks(1);
    check("t6_underrun_one_cycle", bus.tx_underrun, 0);
    wait_clks(3);
    xfer_bits(8'h12, 8, mi);
    check("t6_miso_w0", mi, 8'h00);
    xfer_bits(8'h34, 8, mi);
    check("t6_miso_w1", mi, 8'h77);
    cs_high();
    check("t6_rx_data", bus.rx_data, 8'h34);
    check("sb_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
